// File: rtl/disp_scan_ctrl_pkg.sv
// Shared types and glyph table for the seven-segment scan controller.
package disp_pkg;
  localparam int NDIG = 8;
  localparam int IDXW = $clog2(NDIG);

  typedef logic [6:0] seg_t;

  typedef struct packed {
    logic [3:0] dig;
    logic       dp;
  } disp_entry_t;

  // Segment order {g,f,e,d,c,b,a}; codes 10..15 render as a blank glyph.
  localparam seg_t GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

  function automatic seg_t digit_to_seg(input logic [3:0] dig);
    return GLYPH[dig];
  endfunction
endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Valid/ready write port carrying one position update for the digit bank.
interface disp_scan_ctrl_if;
  import disp_pkg::*;

  logic            wr_valid;
  logic            wr_ready;
  logic [IDXW-1:0] wr_pos;
  logic [3:0]      wr_dig;
  logic            wr_dp;

  modport master (output wr_valid, wr_pos, wr_dig, wr_dp, input wr_ready);
  modport slave  (input wr_valid, wr_pos, wr_dig, wr_dp, output wr_ready);
endinterface

// File: rtl/disp_scan_ctrl_seg_decoder.sv
// Combinational digit-to-segment lookup on the lit-digit read path.
module seg_decoder
  import disp_pkg::*;
(
  input  logic [3:0] dig,
  output seg_t       seg
);
  assign seg = digit_to_seg(dig);
endmodule

// File: rtl/disp_scan_ctrl.sv
// Seven-segment scan controller: register file, single-entry write buffer,
// slot counter with blanking gap, and registered pin outputs.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  disp_scan_ctrl_if.slave  wr,
  output seg_t             seg,
  output logic             dp,
  output logic [NDIG-1:0]  an
);
  localparam int              CW        = $clog2(PRESCALE);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]   CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NDIG - 1);
  localparam logic [IDXW-1:0] IDX_ONE   = IDXW'(1);
  localparam logic [NDIG-1:0] AN_ONE    = NDIG'(1);

  logic [CW-1:0]   cnt;
  logic [IDXW-1:0] idx;
  disp_entry_t     mem [NDIG];

  logic            pend_v;
  logic [IDXW-1:0] pend_pos;
  disp_entry_t     pend_ent;

  disp_entry_t     cur;
  seg_t            glyph;
  logic            slot_end;
  logic            commit;

  assign wr.wr_ready = ~pend_v;
  assign slot_end    = (cnt == CNT_LAST);
  // Commits only land on a slot boundary or while dark, so the lit digit never tears.
  assign commit      = pend_v & (~enable | slot_end);
  assign cur         = mem[idx];

  seg_decoder u_dec (
    .dig (cur.dig),
    .seg (glyph)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= '0;
      pend_v   <= 1'b0;
      pend_pos <= '0;
      pend_ent <= '0;
      for (int i = 0; i < NDIG; i++) mem[i] <= '0;
      an       <= '1;
      seg      <= '0;
      dp       <= 1'b0;
    end else begin
      if (!enable) begin
        cnt <= '0;
        idx <= '0;
      end else if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
      end else begin
        cnt <= cnt + CNT_ONE;
      end

      if (commit) begin
        mem[pend_pos] <= pend_ent;
        pend_v        <= 1'b0;
      end else if (wr.wr_valid && !pend_v) begin
        pend_v       <= 1'b1;
        pend_pos     <= wr.wr_pos;
        pend_ent.dig <= wr.wr_dig;
        pend_ent.dp  <= wr.wr_dp;
      end

      // Leading cycles of each slot stay dark so the previous digit cannot ghost.
      if (!enable || cnt < CNT_BLANK) begin
        an  <= '1;
        seg <= '0;
        dp  <= 1'b0;
      end else begin
        an  <= ~(AN_ONE << idx);
        seg <= glyph;
        dp  <= cur.dp;
      end
    end
  end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl at PRESCALE=8, BLANK_CYC=2.
module tb_disp_scan_ctrl;
  localparam int PS = 8;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       rdy;
  } obs_t;

  localparam logic [6:0] GLYPH_REF [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };
  localparam logic [7:0] AN_SEQ [9] = '{
    8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE
  };

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;

  disp_scan_ctrl_if wr();

  disp_scan_ctrl #(.PRESCALE(PS), .BLANK_CYC(2)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .wr     (wr),
    .seg    (seg),
    .dp     (dp),
    .an     (an)
  );

  always #5 clock = ~clock;

  obs_t exp_q [$];
  obs_t obs_q [$];
  obs_t last;
  int   n_pass = 0;
  int   n_total = 0;

  // Reference state: what the display should hold, per the block's contract.
  logic [3:0] m_dig [8];
  logic       m_dp  [8];
  logic       m_pend;
  logic [2:0] m_pos;
  logic [3:0] m_pdig;
  logic       m_pdp;
  int         m_cnt, m_idx;

  task automatic tick();
    obs_t e;
    logic bnd;
    e = '0;
    if (reset) begin
      e = '{8'hFF, 7'h00, 1'b0, 1'b1};
      m_cnt = 0; m_idx = 0; m_pend = 1'b0;
      for (int i = 0; i < 8; i++) begin m_dig[i] = 4'd0; m_dp[i] = 1'b0; end
    end else begin
      if (!enable || m_cnt < 2) begin
        e.an = 8'hFF; e.seg = 7'h00; e.dp = 1'b0;
      end else begin
        e.an = ~(8'h01 << m_idx); e.seg = GLYPH_REF[m_dig[m_idx]]; e.dp = m_dp[m_idx];
      end
      bnd = enable && (m_cnt == PS - 1);
      if (m_pend && (!enable || bnd)) begin
        m_dig[m_pos] = m_pdig; m_dp[m_pos] = m_pdp; m_pend = 1'b0;
      end else if (wr.wr_valid && !m_pend) begin
        m_pend = 1'b1; m_pos = wr.wr_pos; m_pdig = wr.wr_dig; m_pdp = wr.wr_dp;
      end
      if (!enable) begin m_cnt = 0; m_idx = 0; end
      else if (bnd) begin m_cnt = 0; m_idx = (m_idx + 1) % 8; end
      else m_cnt++;
      e.rdy = !m_pend;
    end
    exp_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    last.an = an; last.seg = seg; last.dp = dp; last.rdy = wr.wr_ready;
    obs_q.push_back(last);
  endtask

  // Holds wr_valid until accepted; leaves wr_valid asserted for the caller.
  task automatic do_write(input logic [2:0] pos, input logic [3:0] d, input logic p,
                          output bit ok, output int n);
    wr.wr_valid = 1'b1; wr.wr_pos = pos; wr.wr_dig = d; wr.wr_dp = p;
    ok = 1'b0; n = 0;
    while (n < 40 && !ok) begin
      ok = (wr.wr_ready === 1'b1);
      tick();
      n++;
    end
  endtask

  task automatic run_until_an(input logic [7:0] target, input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      tick();
      found = (last.an === target);
    end
  endtask

  task automatic test_reset();
    obs_t e, o;
    enable = 1'b0; reset = 1'b1;
    wr.wr_valid = 1'b1; wr.wr_pos = 3'd4; wr.wr_dig = 4'd8; wr.wr_dp = 1'b1;
    repeat (3) tick();
    n_total++;
    if (last.an !== 8'hFF || last.seg !== 7'h00 || last.dp !== 1'b0 || last.rdy !== 1'b1)
      $display("FAIL reset_state: an=%h seg=%h dp=%b rdy=%b, want FF 00 0 1",
               last.an, last.seg, last.dp, last.rdy);
    else n_pass++;
    reset = 1'b0; wr.wr_valid = 1'b0; enable = 1'b1;
    repeat (18) tick();
    n_total++;
    if (obs_q[4].an !== 8'hFF || obs_q[5].an !== 8'hFE || obs_q[5].seg !== 7'h3F ||
        obs_q[10].an !== 8'hFE || obs_q[12].an !== 8'hFF || obs_q[13].an !== 8'hFD)
      $display("FAIL first_slots: an[4,5,10,12,13]=%h %h %h %h %h seg5=%h, want FF FE FE FF FD 3F",
               obs_q[4].an, obs_q[5].an, obs_q[10].an, obs_q[12].an, obs_q[13].an, obs_q[5].seg);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL reset_scan: got %h/%h/%b/%b want %h/%h/%b/%b",
                            o.an, o.seg, o.dp, o.rdy, e.an, e.seg, e.dp, e.rdy);
      else n_pass++;
    end
  endtask

  task automatic test_digit();
    obs_t e, o;
    bit ok, found;
    int n;
    do_write(3'd3, 4'd7, 1'b1, ok, n);
    wr.wr_valid = 1'b0;
    n_total++;
    if (!ok || last.rdy !== 1'b0) $display("FAIL digit_accept: ok=%b rdy=%b, want 1 0", ok, last.rdy);
    else n_pass++;
    repeat (PS) tick();
    n_total++;
    if (last.rdy !== 1'b1) $display("FAIL digit_ready_back: rdy=%b, want 1", last.rdy);
    else n_pass++;
    run_until_an(8'hF7, 80, found);
    n_total++;
    if (!found || last.seg !== 7'h07 || last.dp !== 1'b1)
      $display("FAIL digit_show: found=%b seg=%h dp=%b, want 1 07 1", found, last.seg, last.dp);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL digit_scan: got %h/%h/%b/%b want %h/%h/%b/%b",
                            o.an, o.seg, o.dp, o.rdy, e.an, e.seg, e.dp, e.rdy);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    bit ok1, ok2, f1, f2;
    int n1, n2;
    logic [6:0] s1;
    do_write(3'd1, 4'd9, 1'b0, ok1, n1);
    do_write(3'd2, 4'd4, 1'b0, ok2, n2);
    wr.wr_valid = 1'b0;
    n_total++;
    if (!ok1 || !ok2 || n2 < 2)
      $display("FAIL b2b_accept: ok1=%b ok2=%b wait2=%0d, want 1 1 >=2", ok1, ok2, n2);
    else n_pass++;
    repeat (PS) tick();
    run_until_an(8'hFD, 80, f1);
    s1 = last.seg;
    run_until_an(8'hFB, 16, f2);
    n_total++;
    if (!f1 || !f2 || s1 !== 7'h6F || last.seg !== 7'h66)
      $display("FAIL b2b_show: found=%b%b seg1=%h seg2=%h, want 11 6F 66", f1, f2, s1, last.seg);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL b2b_scan: got %h/%h/%b/%b want %h/%h/%b/%b",
                            o.an, o.seg, o.dp, o.rdy, e.an, e.seg, e.dp, e.rdy);
      else n_pass++;
    end
  endtask

  task automatic test_blank_glyph();
    obs_t e, o;
    bit ok, found;
    int n;
    do_write(3'd5, 4'd12, 1'b0, ok, n);
    wr.wr_valid = 1'b0;
    repeat (PS) tick();
    run_until_an(8'hDF, 80, found);
    n_total++;
    if (!ok || !found || last.seg !== 7'h00 || last.dp !== 1'b0)
      $display("FAIL blank_show: ok=%b found=%b seg=%h dp=%b, want 1 1 00 0", ok, found, last.seg, last.dp);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL blank_scan: got %h/%h/%b/%b want %h/%h/%b/%b",
                            o.an, o.seg, o.dp, o.rdy, e.an, e.seg, e.dp, e.rdy);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    int base;
    bit good;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    base = obs_q.size();
    repeat (9 * PS) tick();
    for (int j = 0; j < 9; j++) begin
      good = (obs_q[base + j*PS].an === 8'hFF) && (obs_q[base + j*PS + 1].an === 8'hFF);
      for (int k = 2; k < PS; k++) good &= (obs_q[base + j*PS + k].an === AN_SEQ[j]);
      n_total++;
      if (!good) $display("FAIL wrap_slot%0d: an at slot start/lit=%h/%h, want FF/%h",
                          j, obs_q[base + j*PS].an, obs_q[base + j*PS + 2].an, AN_SEQ[j]);
      else n_pass++;
    end
    n_total++;
    if (obs_q[base + 4*PS + 2].seg !== 7'h3F)
      $display("FAIL reset_write_ignored: idx4 seg=%h, want 3F", obs_q[base + 4*PS + 2].seg);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL wrap_scan: got %h/%h/%b/%b want %h/%h/%b/%b",
                            o.an, o.seg, o.dp, o.rdy, e.an, e.seg, e.dp, e.rdy);
      else n_pass++;
    end
  endtask

  task automatic test_enable_and_reset();
    obs_t e, o;
    bit ok, found;
    int n, sz;
    repeat (3) tick();
    do_write(3'd6, 4'd8, 1'b1, ok, n);
    wr.wr_valid = 1'b0;
    enable = 1'b0;
    tick();
    n_total++;
    if (!ok || last.an !== 8'hFF || last.rdy !== 1'b1)
      $display("FAIL enable_drop: ok=%b an=%h rdy=%b, want 1 FF 1", ok, last.an, last.rdy);
    else n_pass++;
    enable = 1'b1;
    repeat (3) tick();
    sz = obs_q.size();
    n_total++;
    if (obs_q[sz-3].an !== 8'hFF || obs_q[sz-2].an !== 8'hFF || obs_q[sz-1].an !== 8'hFE)
      $display("FAIL enable_restart: an=%h %h %h, want FF FF FE",
               obs_q[sz-3].an, obs_q[sz-2].an, obs_q[sz-1].an);
    else n_pass++;
    run_until_an(8'hBF, 80, found);
    n_total++;
    if (!found || last.seg !== 7'h7F || last.dp !== 1'b1)
      $display("FAIL enable_commit: found=%b seg=%h dp=%b, want 1 7F 1", found, last.seg, last.dp);
    else n_pass++;
    repeat (5) tick();
    do_write(3'd3, 4'd9, 1'b0, ok, n);
    wr.wr_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++;
    if (last.an !== 8'hFF || last.rdy !== 1'b1)
      $display("FAIL midscan_reset: an=%h rdy=%b, want FF 1", last.an, last.rdy);
    else n_pass++;
    run_until_an(8'hF7, 80, found);
    n_total++;
    if (!found || last.seg !== 7'h3F || last.dp !== 1'b0)
      $display("FAIL reset_mem_clear: found=%b seg=%h dp=%b, want 1 3F 0", found, last.seg, last.dp);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL enable_scan: got %h/%h/%b/%b want %h/%h/%b/%b",
                            o.an, o.seg, o.dp, o.rdy, e.an, e.seg, e.dp, e.rdy);
      else n_pass++;
    end
  endtask

  initial begin
    wr.wr_valid = 1'b0; wr.wr_pos = 3'd0; wr.wr_dig = 4'd0; wr.wr_dp = 1'b0;
    test_reset();
    test_digit();
    test_back_to_back();
    test_blank_glyph();
    test_wrap();
    test_enable_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end
endmodule
